// File: rtl/uart_program_loader.sv
// UART boot loader: receives 8N1 bytes, assembles little-endian 32-bit words and
// writes them into instruction memory, holding the core in reset until the load completes.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int IMEM_ADDR_W  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uart_rx,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   cpu_hold,
    output logic                   load_done,
    output logic                   frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic [1:0] {L_LEN, L_LOAD, L_DONE} load_state_t;

    logic             rx_m;
    logic             rx_s;
    bit_state_t       bstate;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             stop_wait;
    logic             byte_valid;

    load_state_t      lstate;
    logic [1:0]       len_idx;
    logic [1:0]       byte_idx;
    logic [31:0]      n_words;
    logic [31:0]      word_idx;
    logic [23:0]      asm_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bstate     <= B_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            stop_wait  <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (bstate)
                B_IDLE: begin
                    if (!rx_s) begin
                        cnt    <= HALF_BIT;
                        bstate <= B_START;
                    end
                end
                B_START: begin
                    if (cnt == '0) begin
                        if (rx_s) begin
                            bstate <= B_IDLE;
                        end else begin
                            cnt     <= FULL_BIT;
                            bit_idx <= '0;
                            bstate  <= B_DATA;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                B_DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= FULL_BIT;
                        if (bit_idx == 3'd7) begin
                            bstate <= B_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    // A low stop bit parks here until the line returns high, so a
                    // stuck-low line never produces bytes.
                    if (stop_wait) begin
                        if (rx_s) begin
                            stop_wait <= 1'b0;
                            bstate    <= B_IDLE;
                        end
                    end else if (cnt == '0) begin
                        if (rx_s) begin
                            byte_valid <= 1'b1;
                            bstate     <= B_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            stop_wait <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lstate     <= L_LEN;
            len_idx    <= '0;
            byte_idx   <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            asm_word   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
        end else begin
            case (lstate)
                L_LEN: begin
                    if (byte_valid) begin
                        n_words[{len_idx, 3'b000} +: 8] <= shreg;
                        len_idx <= len_idx + 1'b1;
                        if (len_idx == 2'd3) begin
                            if ({shreg, n_words[23:0]} == 32'd0) begin
                                lstate    <= L_DONE;
                                load_done <= 1'b1;
                                cpu_hold  <= 1'b0;
                            end else begin
                                lstate    <= L_LOAD;
                                word_idx  <= '0;
                                byte_idx  <= '0;
                                imem_addr <= '0;
                            end
                        end
                    end
                end
                L_LOAD: begin
                    // The word index advances in the cycle after the strobe.
                    if (imem_we) begin
                        imem_we  <= 1'b0;
                        word_idx <= word_idx + 32'd1;
                        if (word_idx + 32'd1 == n_words) begin
                            lstate    <= L_DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end
                    end else if (byte_valid) begin
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {shreg, asm_word};
                            imem_addr  <= word_idx[IMEM_ADDR_W-1:0];
                        end else begin
                            asm_word[{byte_idx, 3'b000} +: 8] <= shreg;
                        end
                    end
                end
                default: begin
                    imem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
